shift_issue: RTL and testbench
==============================

# shift_issue

Issue stage for the ALU shift unit. Decodes the RV64I shift instructions (SLL/SRL/SRA, SLLI/SRLI/SRAI, SLLW/SRLW/SRAW, SLLIW/SRLIW/SRAIW) into the shift unit's `src1`/`src2`/`shift_control` operand triple. Results are registered behind a valid/ready handshake with a two-entry skid buffer. Sits between the decode/register-read stage and the combinational shifter, and gives full throughput with fully registered outputs.

## Interface
- `SHIFT_ILLEGAL`, 4'hF: `shift_control` code driven for non-shift or reserved encodings. The shifter outputs 0 for this code.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush. Drops all buffered entries.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  block can accept. Driven directly from a flop.
- `inst`  in  32  raw instruction word.
- `rs1_data`  in  64  rs1 register value.
- `rs2_data`  in  64  rs2 register value.
- `out_valid`  out  1  operand triple is valid.
- `out_ready`  in  1  downstream accepts.
- `src1`  out  64  equals `rs1_data`.
- `src2`  out  64  shift amount operand.
- `shift_control`  out  4  0 ArithRight32, 1 LogicalRight32, 2 LogicalLeft32, 3 LogicalRight64, 4 LogicalLeft64, 5 ArithRight64, `SHIFT_ILLEGAL` otherwise.
- `illegal`  out  1  the entry is not a legal shift instruction.

## Operation
Decode is combinational on the input side; the result is captured on accept.
- **opcode 0110011, funct7 0000000:**
  - funct3 001 → 4 (SLL).
  - funct3 101 → 3 (SRL).
- **opcode 0110011, funct7 0100000, funct3 101** → 5 (SRA).
- **opcode 0010011:**
  - funct3 001, inst[31:26]=000000 → 4 (SLLI).
  - funct3 101, inst[31:26]=000000 → 3 (SRLI).
  - funct3 101, inst[31:26]=010000 → 5 (SRAI).
- **opcode 0111011:**
  - funct7 0000000, funct3 001 → 2 (SLLW).
  - funct7 0000000, funct3 101 → 1 (SRLW).
  - funct7 0100000, funct3 101 → 0 (SRAW).
- **opcode 0011011:**
  - inst[31:25]=0000000, funct3 001 → 2 (SLLIW).
  - inst[31:25]=0000000, funct3 101 → 1 (SRLIW).
  - inst[31:25]=0100000, funct3 101 → 0 (SRAIW).
- **Any other encoding:** `shift_control=SHIFT_ILLEGAL`, `illegal=1`. This includes SLLIW/SRLIW/SRAIW with inst[25]=1.
- **`src2` for register forms:** `rs2_data` unmodified. The shifter uses only src2[5:0] or src2[4:0].
- **`src2` for immediate 64-bit forms:** `{58'b0, inst[25:20]}`.
- **`src2` for immediate W forms:** `{59'b0, inst[24:20]}`.
- **`src1`:** always `rs1_data`. Illegal entries still carry `src1`/`src2` as decoded; downstream ignores them.
- **Buffering:**
  - Main output register (`out_*`) plus one skid register.
  - Accept occurs when `in_valid && in_ready`.
  - If the main register is empty, or is draining this cycle (`out_ready`), the accepted entry goes to the main register.
  - Otherwise the accepted entry goes to the skid register, and `in_ready` drops the next cycle.
  - When the main register drains and the skid register is full, the skid entry moves to main and `in_ready` rises the next cycle.
- **Ordering:** entries leave in strict acceptance order; none are duplicated or dropped.

## Timing
- **Reset:** `out_valid=0`, `in_ready=1`, skid empty, `src1=0`, `src2=0`, `shift_control=SHIFT_ILLEGAL`, `illegal=0`.
- **Latency:** an accept at edge N makes the entry visible on outputs after edge N (1 cycle). Sustains 1 entry/cycle with `out_ready` held high.
- **Stable output:** while `out_valid && !out_ready`, every output stays stable.
- **`in_ready` in the steady case:** equals "skid empty" and never depends combinationally on `out_ready`.
- **Priority:** `rst` > `flush` > normal operation.
- **Flush:** clears main and skid valid and forces `in_ready=1` next cycle. An input presented in the flush cycle is not accepted. Data registers may hold stale values.
- **Reset mid-stream:** all buffered entries are lost; state is identical to post-reset.
- **Simultaneous accept + drain with skid full:** cannot occur, because `in_ready=0`.
- **Simultaneous accept + drain with skid empty:** the new entry replaces main and `out_valid` stays 1.

## Test plan
- **SRAIW, stalled downstream.** Reset, then `inst=0x4031509B` (SRAIW x1,x2,3), `rs1_data=0xFFFF_FFFF_8000_0000`, `out_ready=0`. Next cycle: `out_valid=1`, `shift_control=0`, `src2=3`, `src1` = input, `illegal=0`, `in_ready` still 1.
- **Back-to-back, mixed forms.** `out_ready=1` continuously; send `inst=0x005211B3` (SLL, `rs2_data=0x1_0000_0041`), then `0x03F0D093` (SRLI 63). Outputs are, on consecutive cycles:
  - `shift_control=4`, `src2=0x1_0000_0041`.
  - `shift_control=3`, `src2=63`.
- **Backpressure.** Hold `out_ready=0` and send 3 entries A, B, C.
  - A lands in main, B in skid; `in_ready=0` from the cycle after B's accept; C is held upstream.
  - Raise `out_ready` and confirm the order A, B, C with no loss.
- **Illegal encodings.**
  - `inst=0x0201109B` (SLLIW shamt 32) → `illegal=1`, `shift_control=4'hF`.
  - `inst=0x00000013` (ADDI) → `illegal=1`, `shift_control=4'hF`.
- **Flush.** Fill main and skid (`out_ready=0`), pulse `flush` while `in_valid=1`. Next cycle: `out_valid=0`, `in_ready=1`, and the flushed-cycle input never appears.
- **Reset mid-stream.** Assert `rst` while `out_valid=1` and the skid is full. Next cycle all outputs hold their reset values.

Source files
------------

// File: rtl/shift_issue_if.sv
// Handshake bundle between decode/register-read, the shift issue stage and the shifter.
// The master side drives instructions and out_ready; the slave side (issue stage) returns operands.
interface shift_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [3:0]  shift_control;
  logic        illegal;

  modport master (
    output in_valid, inst, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, src1, src2, shift_control, illegal
  );

  modport slave (
    input  in_valid, inst, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, src1, src2, shift_control, illegal
  );
endinterface

// File: rtl/shift_issue.sv
// RV64I shift decode into {src1, src2, shift_control}; 1-cycle latency, registered outputs.
// Backpressure: a skid register absorbs one entry when stalled; in_ready is a flop equal to "skid empty".
module shift_issue (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  shift_issue_if.slave   bus
);
  localparam logic [3:0] SHIFT_ILLEGAL = 4'hF;

  typedef struct packed {
    logic [63:0] src1;
    logic [63:0] src2;
    logic [3:0]  shift_control;
    logic        illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{src1: 64'd0, src2: 64'd0,
                                   shift_control: SHIFT_ILLEGAL, illegal: 1'b0};

  entry_t main_q, main_n, skid_q, skid_n, dec;
  logic   main_vld_q, main_vld_n, skid_vld_q, skid_vld_n;
  logic   in_ready_q;
  logic   accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.inst[6:0];
  assign funct3 = bus.inst[14:12];
  assign funct7 = bus.inst[31:25];

  always_comb begin
    dec               = '0;
    dec.src1          = bus.rs1_data;
    dec.src2          = bus.rs2_data;
    dec.shift_control = SHIFT_ILLEGAL;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b001) dec.shift_control = 4'd4;
        if (funct7 == 7'b0000000 && funct3 == 3'b101) dec.shift_control = 4'd3;
        if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.shift_control = 4'd5;
      end
      7'b0010011: begin
        dec.src2 = {58'b0, bus.inst[25:20]};
        if (funct3 == 3'b001 && bus.inst[31:26] == 6'b000000) dec.shift_control = 4'd4;
        if (funct3 == 3'b101 && bus.inst[31:26] == 6'b000000) dec.shift_control = 4'd3;
        if (funct3 == 3'b101 && bus.inst[31:26] == 6'b010000) dec.shift_control = 4'd5;
      end
      7'b0111011: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b001) dec.shift_control = 4'd2;
        if (funct7 == 7'b0000000 && funct3 == 3'b101) dec.shift_control = 4'd1;
        if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.shift_control = 4'd0;
      end
      7'b0011011: begin
        // W immediates only have a 5-bit shamt; inst[25] set is reserved.
        dec.src2 = {59'b0, bus.inst[24:20]};
        if (funct7 == 7'b0000000 && funct3 == 3'b001) dec.shift_control = 4'd2;
        if (funct7 == 7'b0000000 && funct3 == 3'b101) dec.shift_control = 4'd1;
        if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.shift_control = 4'd0;
      end
      default: dec.shift_control = SHIFT_ILLEGAL;
    endcase
    dec.illegal = (dec.shift_control == SHIFT_ILLEGAL);
  end

  assign accept = bus.in_valid && in_ready_q && !flush;

  always_comb begin
    main_n     = main_q;
    skid_n     = skid_q;
    main_vld_n = main_vld_q;
    skid_vld_n = skid_vld_q;
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (main_vld_q && !bus.out_ready) begin
      if (accept) begin
        skid_n     = dec;
        skid_vld_n = 1'b1;
      end
    end else if (skid_vld_q) begin
      // in_ready was low, so no accept can collide with the skid refill.
      main_n     = skid_q;
      main_vld_n = 1'b1;
      skid_vld_n = 1'b0;
    end else if (accept) begin
      main_n     = dec;
      main_vld_n = 1'b1;
    end else begin
      main_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      main_vld_q <= main_vld_n;
      skid_vld_q <= skid_vld_n;
      in_ready_q <= !skid_vld_n;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = main_vld_q;
  assign bus.src1          = main_q.src1;
  assign bus.src2          = main_q.src2;
  assign bus.shift_control = main_q.shift_control;
  assign bus.illegal       = main_q.illegal;
endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue: decode forms, handshake, skid buffering, flush and reset.
module tb_shift_issue;
  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_fail;

  shift_issue_if bus ();

  shift_issue dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [31:0] i, input logic [63:0] r1, input logic [63:0] r2);
    bus.in_valid = 1'b1;
    bus.inst     = i;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    bus.inst = 32'h0;
    bus.rs1_data = 64'h0;
    bus.rs2_data = 64'h0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.shift_control, bus.illegal} !== {1'b0, 1'b1, 4'hF, 1'b0}
        || bus.src1 !== 64'd0 || bus.src2 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: vld/rdy/ctl/ill=%b/%b/%h/%b src1=%h src2=%h, need 0/1/f/0 src1=0 src2=0",
               bus.out_valid, bus.in_ready, bus.shift_control, bus.illegal, bus.src1, bus.src2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sraiw_stall;
    bus.out_ready = 1'b0;
    send(32'h4031509B, 64'hFFFF_FFFF_8000_0000, 64'h1234);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.shift_control, bus.illegal} !== {1'b1, 1'b1, 4'd0, 1'b0}
        || bus.src1 !== 64'hFFFF_FFFF_8000_0000 || bus.src2 !== 64'd3) begin
      n_fail++;
      $display("FAIL sraiw: vld/rdy/ctl/ill=%b/%b/%h/%b src1=%h src2=%h, need 1/1/0/0 src1=ffffffff80000000 src2=3",
               bus.out_valid, bus.in_ready, bus.shift_control, bus.illegal, bus.src1, bus.src2);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.shift_control !== 4'd0 || bus.src2 !== 64'd3) begin
      n_fail++;
      $display("FAIL sraiw_hold: vld=%b ctl=%h src2=%h, need 1/0/3", bus.out_valid, bus.shift_control, bus.src2);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sraiw_drain: out_valid=%b, need 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] insts [10];
    logic [3:0]  ctls  [10];
    logic [63:0] src2s [10];
    bus.out_ready = 1'b1;
    send(32'h005211B3, 64'hA5, 64'h1_0000_0041);
    @(negedge clk);
    send(32'h03F0D093, 64'hB6, 64'h77);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.shift_control !== 4'd4 || bus.src2 !== 64'h1_0000_0041 || bus.src1 !== 64'hA5) begin
      n_fail++;
      $display("FAIL b2b_sll: vld=%b ctl=%h src1=%h src2=%h, need 1/4/a5/100000041",
               bus.out_valid, bus.shift_control, bus.src1, bus.src2);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.shift_control !== 4'd3 || bus.src2 !== 64'd63 || bus.src1 !== 64'hB6) begin
      n_fail++;
      $display("FAIL b2b_srli: vld=%b ctl=%h src1=%h src2=%h, need 1/3/b6/3f",
               bus.out_valid, bus.shift_control, bus.src1, bus.src2);
    end
    // Remaining decode forms streamed one per cycle.
    insts = '{32'h0020D0B3, 32'h4020D0B3, 32'h0020D0BB, 32'h002090BB, 32'h4020D0BB,
              32'h4280D093, 32'h00509093, 32'h0070D09B, 32'h01F0909B, 32'h4031509B};
    ctls  = '{4'd3, 4'd5, 4'd1, 4'd2, 4'd0, 4'd5, 4'd4, 4'd1, 4'd2, 4'd0};
    src2s = '{64'hC0DE, 64'hC0DE, 64'hC0DE, 64'hC0DE, 64'hC0DE,
              64'd40, 64'd5, 64'd7, 64'd31, 64'd3};
    for (int k = 0; k < 10; k++) begin
      send(insts[k], 64'h100 + 64'(k), 64'hC0DE);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.shift_control !== ctls[k]
          || bus.src2 !== src2s[k] || bus.src1 !== 64'h100 + 64'(k) || bus.illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL decode[%0d]: inst=%h vld=%b rdy=%b ctl=%h ill=%b src1=%h src2=%h, need ctl=%h src2=%h",
                 k, insts[k], bus.out_valid, bus.in_ready, bus.shift_control, bus.illegal,
                 bus.src1, bus.src2, ctls[k], src2s[k]);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_empty: out_valid=%b, need 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    send(32'h4020D0B3, 64'hAAAA, 64'd1);
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.shift_control} !== {1'b1, 1'b1, 4'd5} || bus.src1 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL bp_a_main: vld/rdy/ctl=%b/%b/%h src1=%h, need 1/1/5 aaaa",
               bus.out_valid, bus.in_ready, bus.shift_control, bus.src1);
    end
    send(32'h0020D0BB, 64'hBBBB, 64'd2);
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.shift_control} !== {1'b1, 1'b0, 4'd5} || bus.src1 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL bp_b_skid: vld/rdy/ctl=%b/%b/%h src1=%h, need 1/0/5 aaaa",
               bus.out_valid, bus.in_ready, bus.shift_control, bus.src1);
    end
    send(32'h002090BB, 64'hCCCC, 64'd3);
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.shift_control} !== {1'b1, 1'b0, 4'd5} || bus.src1 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL bp_c_held: vld/rdy/ctl=%b/%b/%h src1=%h, need 1/0/5 aaaa",
               bus.out_valid, bus.in_ready, bus.shift_control, bus.src1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.shift_control} !== {1'b1, 1'b1, 4'd1} || bus.src1 !== 64'hBBBB) begin
      n_fail++;
      $display("FAIL bp_b_out: vld/rdy/ctl=%b/%b/%h src1=%h, need 1/1/1 bbbb",
               bus.out_valid, bus.in_ready, bus.shift_control, bus.src1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.shift_control} !== {1'b1, 1'b1, 4'd2} || bus.src1 !== 64'hCCCC) begin
      n_fail++;
      $display("FAIL bp_c_out: vld/rdy/ctl=%b/%b/%h src1=%h, need 1/1/2 cccc",
               bus.out_valid, bus.in_ready, bus.shift_control, bus.src1);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: out_valid=%b, need 0 (duplicate entry)", bus.out_valid);
    end
  endtask

  task automatic test_illegal;
    bus.out_ready = 1'b1;
    send(32'h0201109B, 64'h11, 64'h22);
    @(negedge clk);
    send(32'h00000013, 64'h33, 64'h44);
    n_checks++;
    if ({bus.out_valid, bus.illegal, bus.shift_control} !== {1'b1, 1'b1, 4'hF}) begin
      n_fail++;
      $display("FAIL illegal_slliw32: vld/ill/ctl=%b/%b/%h, need 1/1/f",
               bus.out_valid, bus.illegal, bus.shift_control);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.illegal, bus.shift_control} !== {1'b1, 1'b1, 4'hF} || bus.src1 !== 64'h33) begin
      n_fail++;
      $display("FAIL illegal_addi: vld/ill/ctl=%b/%b/%h src1=%h, need 1/1/f 33",
               bus.out_valid, bus.illegal, bus.shift_control, bus.src1);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b0;
    send(32'h005211B3, 64'h1, 64'h1);
    @(negedge clk);
    send(32'h0020D0B3, 64'h2, 64'h2);
    @(negedge clk);
    send(32'h4020D0BB, 64'hDEAD, 64'h3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush: vld/rdy=%b/%b, need 0/1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_drop: vld/rdy=%b/%b src1=%h, need 0/1 (flushed input must not appear)",
               bus.out_valid, bus.in_ready, bus.src1);
    end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    send(32'h03F0D093, 64'h5, 64'h5);
    @(negedge clk);
    send(32'h0070D09B, 64'h6, 64'h6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_full: vld/rdy=%b/%b, need 1/0", bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.shift_control, bus.illegal} !== {1'b0, 1'b1, 4'hF, 1'b0}
        || bus.src1 !== 64'd0 || bus.src2 !== 64'd0) begin
      n_fail++;
      $display("FAIL rstmid: vld/rdy/ctl/ill=%b/%b/%h/%b src1=%h src2=%h, need 0/1/f/0 0 0",
               bus.out_valid, bus.in_ready, bus.shift_control, bus.illegal, bus.src1, bus.src2);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_skid_lost: vld/rdy=%b/%b, need 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sraiw_stall();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
